daq_buffer_reader: RTL and testbench
====================================

# daq_buffer_reader

Drain engine for the DAQ event buffer. On a `start` command it reads a contiguous run of 32-bit words from the buffer's 64-bit read port, starting at an even word address and wrapping modulo 32768 words. It absorbs the buffer's fixed 2-cycle read latency and presents the data as a valid/ready stream of 64-bit beats with backpressure. It sits between the buffer read port (`addrb` / `doutb64`) and the readout link framer, in the buffer's read-clock domain.

## Interface
- `ADDR_W`, 15: buffer address width in 32-bit words.
- `FIFO_DEPTH`, 8: output skid FIFO depth in beats; must be a power of 2 and at least 4.
- `clk` in 1: clock; also drives the buffer read clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: command strobe; sampled only while idle.
- `start_addr` in 15: first 32-bit word address; bit 0 is ignored and treated as 0.
- `nwords` in 16: number of 32-bit words to read, range 0 to 32768.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `rd_addr` out 15: buffer read address; bit 0 is always 0.
- `rd_data` in 64: buffer `doutb64`; bits [31:0] are the even word, bits [63:32] the odd word.
- `m_data` out 64: output beat.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accepts the beat.
- `m_last` out 1: marks the final beat of the command.
- `m_keep` out 2: half-word enables; 2'b11 means full beat, 2'b01 means only [31:0] valid.

## Operation
- States and transitions:
  - IDLE: `start` moves to RUN, or to DONE when `nwords`==0.
  - RUN: issue reads; when all beats are issued, move to DRAIN.
  - DRAIN: when the FIFO is empty and the pipeline holds nothing in flight, move to DONE.
  - DONE: for one cycle, then IDLE.
- On `start` in IDLE, latch:
  - `beats_left` = ceil(`nwords`/2), 15 bits, maximum 16384;
  - beat address = `start_addr`[14:1];
  - `odd_tail` = `nwords`[0].
- Read issue in RUN: one read per cycle while `credits` > 0.
  - `credits` = FIFO_DEPTH − FIFO count − reads in flight.
  - Each issue advances the 14-bit beat address, wrapping 0x3FFF to 0x0000, and decrements `beats_left`.
- A 3-stage valid shift register tracks reads in flight (address register, BRAM latch, DO_REG). Its output pushes `rd_data` into the FIFO, tagged with last/keep for the final beat.
- `m_last`=1 only on the final beat; its `m_keep` is 2'b01 if `odd_tail`, else 2'b11. All other beats carry `m_keep`=2'b11.
- `m_data`, `m_keep` and `m_last` are held stable while `m_valid`=1 and `m_ready`=0.
- `start` while busy is ignored; the latched command is unaffected.
- FIFO push and pop in the same cycle are legal, including when the FIFO is full or empty; credit accounting guarantees no overflow.
- Reset mid-command: state returns to IDLE, FIFO and in-flight tags are flushed, no `done` pulse. Stale BRAM data arriving after reset is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_keep`=0, `m_data`=0, `rd_addr`=0.
- Cycle 0: `start` sampled. `busy`=1 from cycle 1 through the DONE cycle inclusive.
- Cycle 1: first `rd_addr` driven (registered).
- Cycle 3: `rd_data` for that address is valid and pushed into the FIFO.
- Cycle 4: first `m_valid`.
- Throughput: 1 beat/clk sustained when `m_ready` is held at 1.
- `done` is asserted the cycle after the `m_last` beat is accepted. A new `start` is accepted the cycle after `done`.
- `nwords`==0: `done`=1 in cycle 1, no beats emitted.

## Structure
- Shared `daq_pkg`:
  - `DAQ_BUF_AW`=15;
  - `DAQ_BUF_RD_LAT`=2;
  - state enum IDLE/RUN/DRAIN/DONE;
  - beat tag struct {last, keep[1:0]}.
- One sub-module, `daq_sync_fifo`: parameterised width and depth, single clock, first-word-fall-through, exposes count. Instantiated with width 67 (64 data + 3 tag).
- Pipeline-tag shift register and credit counter live in the top level.

## Test plan
- `start_addr`=0x0010, `nwords`=8, `m_ready`=1:
  - 4 beats of words 0x10–0x17; first `m_valid` in cycle 4;
  - `m_last` on beat 4 with `m_keep`=2'b11; `done` the following cycle.
- `nwords`=5 from 0x0100: 3 beats; beat 3 has `m_keep`=2'b01 and `m_last`=1, carrying word 0x104 in [31:0].
- `start_addr`=0x7FFC, `nwords`=8: `rd_addr` sequence 0x7FFC, 0x7FFE, 0x0000, 0x0002; data wraps correctly.
- `m_ready` toggled randomly (including 20 low cycles) over a 64-word read:
  - no beat lost or duplicated; stable data while stalled;
  - reads in flight + FIFO count never exceeds 8.
- Edge commands:
  - `nwords`=0: `done` in cycle 1, no `m_valid`;
  - `nwords`=32768: exactly 16384 beats;
  - second `start` during busy: ignored.
- `rst` asserted mid-command with beats in the FIFO: next cycle `m_valid`=0 and `busy`=0; no `done`; a fresh command afterward returns correct data only.

Source files
------------

// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ event buffer readout path.
package daq_pkg;

  localparam int DAQ_BUF_AW     = 15;
  localparam int DAQ_BUF_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic       last;
    logic [1:0] keep;
  } beat_tag_t;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_LOW  = 2'b01;

endpackage

// File: rtl/daq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Simultaneous push and pop is accepted even when full or empty.
module daq_sync_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/daq_buffer_reader.sv
// Drains a contiguous, wrapping run of words from the event buffer's 64-bit
// read port and streams them as valid/ready beats with backpressure.
module daq_buffer_reader
  import daq_pkg::*;
#(
  parameter int ADDR_W     = DAQ_BUF_AW,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   nwords,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [63:0]       rd_data,
  output logic [63:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [1:0]        m_keep
);

  localparam int BW     = ADDR_W - 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int STAGES = DAQ_BUF_RD_LAT + 1;
  localparam int FW     = 64 + $bits(beat_tag_t);

  state_t            state;
  state_t            state_next;
  logic [BW-1:0]     beat_addr;
  logic [ADDR_W-1:0] beats_left;
  logic              odd_tail;
  logic [STAGES-1:0] pipe_valid;
  beat_tag_t         pipe_tag [STAGES];

  logic [ADDR_W+1:0] nwords_plus;
  logic [ADDR_W-1:0] cmd_beats;
  logic [CW-1:0]     in_flight;
  logic [CW-1:0]     credits;
  logic              issue;
  logic [BW-1:0]     issue_addr;
  logic [ADDR_W-1:0] issue_left;
  logic              issue_odd;
  beat_tag_t         issue_tag;

  logic [FW-1:0]     fifo_out;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              pop;
  beat_tag_t         out_tag;
  logic              addr_lsb_unused;

  assign addr_lsb_unused = start_addr[0];
  assign nwords_plus     = {1'b0, nwords} + (ADDR_W+2)'(1);
  assign cmd_beats       = nwords_plus[ADDR_W:1];

  // Every slot of the output FIFO is reserved the moment its read is issued.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < STAGES; i++) begin
      in_flight = in_flight + CW'(pipe_valid[i]);
    end
    credits = CW'(FIFO_DEPTH) - fifo_count - in_flight;
  end

  // The first read is issued straight from the start command so that its
  // address is already on the port in the first busy cycle.
  always_comb begin
    issue_addr = beat_addr;
    issue_left = beats_left;
    issue_odd  = odd_tail;
    issue      = (state == RUN) && (beats_left != '0) && (credits != '0);
    if (state == IDLE) begin
      issue_addr = start_addr[ADDR_W-1:1];
      issue_left = cmd_beats;
      issue_odd  = nwords[0];
      issue      = start && (nwords != '0);
    end
    issue_tag.last = (issue_left == ADDR_W'(1));
    issue_tag.keep = (issue_tag.last && issue_odd) ? KEEP_LOW : KEEP_FULL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (nwords == '0) ? DONE : RUN;
      RUN:   if (beats_left == '0) state_next = DRAIN;
      DRAIN: if (pipe_valid == '0 &&
                 (fifo_count == '0 || (fifo_count == CW'(1) && pop)))
               state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr    <= '0;
      beat_addr  <= '0;
      beats_left <= '0;
      odd_tail   <= 1'b0;
      pipe_valid <= '0;
      for (int i = 0; i < STAGES; i++) pipe_tag[i] <= '0;
    end else begin
      if (state == IDLE && start) odd_tail <= nwords[0];
      if (issue) begin
        rd_addr    <= {issue_addr, 1'b0};
        beat_addr  <= issue_addr + BW'(1);
        beats_left <= issue_left - ADDR_W'(1);
      end
      pipe_valid  <= {pipe_valid[STAGES-2:0], issue};
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < STAGES; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  daq_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_valid[STAGES-1]),
    .push_data ({pipe_tag[STAGES-1], rd_data}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs are forced to zero while empty so stale storage never shows.
  assign out_tag = beat_tag_t'(fifo_out[FW-1:64]);
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_out[63:0] : '0;
  assign m_last  = m_valid && out_tag.last;
  assign m_keep  = m_valid ? out_tag.keep : 2'b00;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_daq_buffer_reader.sv
// Directed bench for daq_buffer_reader with a 2-cycle-latency buffer model.
module tb_daq_buffer_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] nwords;
  logic        busy;
  logic        done;
  logic [14:0] rd_addr;
  logic [63:0] rd_data;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  m_keep;

  int total = 0;
  int bad   = 0;

  logic [63:0] cap_data [$];
  logic [1:0]  cap_keep [$];
  logic        cap_last [$];
  logic [14:0] addr_seq [$];
  int          done_cyc;
  int          first_valid;
  int          valid_cnt;
  int          stall_err;
  int          max_out;
  logic        busy1;

  daq_buffer_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .nwords     (nwords),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .m_keep     (m_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [14:0] a);
    return {2'b10, a, a};
  endfunction

  function automatic logic [63:0] exp_beat(input logic [14:0] base, input int i);
    logic [14:0] w;
    w = {base[14:1], 1'b0} + 15'(2 * i);
    return {word_at(w + 15'd1), word_at(w)};
  endfunction

  // Buffer model: address registered, then data registered, two cycles total.
  logic [14:0] bram_addr_q;
  always @(posedge clk) begin
    bram_addr_q <= rd_addr;
    rd_data     <= {word_at(bram_addr_q + 15'd1), word_at(bram_addr_q)};
  end

  // Cycle 0 is the cycle start is high; samples taken on the falling edge.
  task automatic run_cmd(input logic [14:0] addr, input int n, input int mode,
                         input int glitch_at, input int budget);
    int          cyc;
    int          issued;
    int          accepted;
    int          extra;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [1:0]  prev_keep;
    logic        prev_last;
    logic [14:0] prev_addr;
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); addr_seq.delete();
    done_cyc = -1; first_valid = -1; valid_cnt = 0; stall_err = 0; max_out = 0;
    busy1 = 1'b0; issued = 0; accepted = 0; extra = 0; prev_stall = 1'b0;
    prev_data = '0; prev_keep = '0; prev_last = 1'b0; prev_addr = '0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = addr; nwords = 16'(n); m_ready = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (cyc == 1) busy1 = busy;
      if (n != 0 && cyc >= 1 && (cyc == 1 || rd_addr != prev_addr)) begin
        issued++;
        addr_seq.push_back(rd_addr);
      end
      prev_addr = rd_addr;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (prev_stall && (!m_valid || m_data !== prev_data ||
                         m_keep !== prev_keep || m_last !== prev_last))
        stall_err++;
      if (m_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data);
        cap_keep.push_back(m_keep);
        cap_last.push_back(m_last);
        accepted++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data; prev_keep = m_keep; prev_last = m_last;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0) extra++;
      if (extra >= 3 || cyc >= budget) break;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == glitch_at);
      if (cyc == glitch_at) begin
        start_addr = 15'h3000;
        nwords     = 16'd2;
      end
      if (mode == 0) m_ready = 1'b1;
      else m_ready = (cyc >= 10 && cyc < 30) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
    total++; if (m_last !== 1'b0 || m_keep !== 2'b00) begin bad++; $display("[TB] FAIL reset_tag: got last=%b keep=%b expected 0/00", m_last, m_keep); end
    total++; if (m_data !== 64'd0) begin bad++; $display("[TB] FAIL reset_data: got %h expected 0", m_data); end
    total++; if (rd_addr !== 15'd0) begin bad++; $display("[TB] FAIL reset_rd_addr: got %h expected 0", rd_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_basic();
    run_cmd(15'h0010, 8, 0, -1, 100);
    total++; if (cap_data.size() !== 4) begin bad++; $display("[TB] FAIL basic_beats: got %0d expected 4", cap_data.size()); end
    total++; if (first_valid !== 4) begin bad++; $display("[TB] FAIL basic_first_valid: got %0d expected 4", first_valid); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy: got %b expected 1", busy1); end
    total++; if (done_cyc !== 8) begin bad++; $display("[TB] FAIL basic_done_cycle: got %0d expected 8", done_cyc); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_beat(15'h0010, i) || cap_keep[i] !== 2'b11 || cap_last[i] !== (i == 3)) begin
        bad++;
        $display("[TB] FAIL basic_beat%0d: got %h/%b/%b expected %h/11/%b", i, cap_data[i], cap_keep[i], cap_last[i], exp_beat(15'h0010, i), (i == 3));
      end
    end
  endtask

  task automatic test_odd_tail();
    run_cmd(15'h0100, 5, 0, -1, 100);
    total++; if (cap_data.size() !== 3) begin bad++; $display("[TB] FAIL odd_beats: got %0d expected 3", cap_data.size()); end
    total++; if (done_cyc !== 7) begin bad++; $display("[TB] FAIL odd_done_cycle: got %0d expected 7", done_cyc); end
    for (int i = 0; i < cap_data.size() && i < 2; i++) begin
      total++;
      if (cap_data[i] !== exp_beat(15'h0100, i) || cap_keep[i] !== 2'b11 || cap_last[i] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL odd_beat%0d: got %h/%b/%b expected %h/11/0", i, cap_data[i], cap_keep[i], cap_last[i], exp_beat(15'h0100, i));
      end
    end
    if (cap_data.size() == 3) begin
      total++;
      if (cap_data[2][31:0] !== word_at(15'h0104) || cap_keep[2] !== 2'b01 || cap_last[2] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL odd_tail_beat: got %h/%b/%b expected %h/01/1", cap_data[2][31:0], cap_keep[2], cap_last[2], word_at(15'h0104));
      end
    end
  endtask

  task automatic test_wrap();
    logic [14:0] exp_addr [4];
    exp_addr[0] = 15'h7FFC; exp_addr[1] = 15'h7FFE; exp_addr[2] = 15'h0000; exp_addr[3] = 15'h0002;
    run_cmd(15'h7FFC, 8, 0, -1, 100);
    total++; if (addr_seq.size() !== 4) begin bad++; $display("[TB] FAIL wrap_addr_count: got %0d expected 4", addr_seq.size()); end
    for (int i = 0; i < addr_seq.size() && i < 4; i++) begin
      total++;
      if (addr_seq[i] !== exp_addr[i]) begin bad++; $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, addr_seq[i], exp_addr[i]); end
    end
    total++; if (cap_data.size() !== 4) begin bad++; $display("[TB] FAIL wrap_beats: got %0d expected 4", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_beat(15'h7FFC, i) || cap_last[i] !== (i == 3)) begin
        bad++;
        $display("[TB] FAIL wrap_beat%0d: got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_beat(15'h7FFC, i), (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    run_cmd(15'h0201, 64, 1, -1, 2000);
    total++; if (cap_data.size() !== 32) begin bad++; $display("[TB] FAIL bp_beats: got %0d expected 32", cap_data.size()); end
    total++; if (done_cyc < 0) begin bad++; $display("[TB] FAIL bp_done: got none expected pulse"); end
    total++; if (stall_err !== 0) begin bad++; $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", stall_err); end
    total++; if (max_out > 8) begin bad++; $display("[TB] FAIL bp_outstanding: got %0d expected at most 8", max_out); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_beat(15'h0200, i) || cap_keep[i] !== 2'b11 || cap_last[i] !== (i == 31)) begin
        bad++;
        $display("[TB] FAIL bp_beat%0d: got %h/%b/%b expected %h/11/%b", i, cap_data[i], cap_keep[i], cap_last[i], exp_beat(15'h0200, i), (i == 31));
      end
    end
  endtask

  task automatic test_zero_words();
    run_cmd(15'h0050, 0, 0, -1, 50);
    total++; if (done_cyc !== 1) begin bad++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("[TB] FAIL zero_busy: got %b expected 1", busy1); end
    total++; if (valid_cnt !== 0) begin bad++; $display("[TB] FAIL zero_valid: got %0d expected 0", valid_cnt); end
  endtask

  task automatic test_max_words();
    int errs;
    errs = 0;
    run_cmd(15'h4000, 32768, 0, -1, 16500);
    total++; if (cap_data.size() !== 16384) begin bad++; $display("[TB] FAIL max_beats: got %0d expected 16384", cap_data.size()); end
    total++; if (done_cyc !== 16388) begin bad++; $display("[TB] FAIL max_done_cycle: got %0d expected 16388", done_cyc); end
    total++; if (max_out > 8) begin bad++; $display("[TB] FAIL max_outstanding: got %0d expected at most 8", max_out); end
    for (int i = 0; i < cap_data.size(); i++) begin
      if (cap_data[i] !== exp_beat(15'h4000, i) || cap_keep[i] !== 2'b11 || cap_last[i] !== (i == 16383))
        errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("[TB] FAIL max_data: got %0d bad beats expected 0", errs); end
  endtask

  task automatic test_start_while_busy();
    run_cmd(15'h0400, 6, 0, 2, 100);
    total++; if (cap_data.size() !== 3) begin bad++; $display("[TB] FAIL busy_start_beats: got %0d expected 3", cap_data.size()); end
    total++; if (done_cyc !== 7) begin bad++; $display("[TB] FAIL busy_start_done: got %0d expected 7", done_cyc); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_beat(15'h0400, i) || cap_last[i] !== (i == 2)) begin
        bad++;
        $display("[TB] FAIL busy_start_beat%0d: got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_beat(15'h0400, i), (i == 2));
      end
    end
  endtask

  task automatic test_reset_mid_command();
    int stray;
    stray = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 15'h0600; nwords = 16'd40; m_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_prefill: got valid=%b expected 1", m_valid); end
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_flush: got valid=%b busy=%b done=%b expected 0/0/0", m_valid, busy, done);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_valid || done) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("[TB] FAIL rstmid_stray: got %0d cycles expected 0", stray); end
    run_cmd(15'h0020, 6, 0, -1, 100);
    total++; if (cap_data.size() !== 3) begin bad++; $display("[TB] FAIL rstmid_fresh_beats: got %0d expected 3", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_beat(15'h0020, i) || cap_last[i] !== (i == 2)) begin
        bad++;
        $display("[TB] FAIL rstmid_fresh_beat%0d: got %h/%b expected %h/%b", i, cap_data[i], cap_last[i], exp_beat(15'h0020, i), (i == 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; nwords = '0; m_ready = 1'b1;
    test_reset();
    test_basic();
    test_odd_tail();
    test_wrap();
    test_backpressure();
    test_zero_words();
    test_start_while_busy();
    test_reset_mid_command();
    test_max_words();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
